// File: rtl/bcd_pkg.sv
// Shared definitions for BCD counters: digit limits, the {tens, ones} pair type
// and the saturating clamp applied to parallel-load values.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    function automatic logic [3:0] bcd_sat(input logic [3:0] value, input logic [3:0] max);
        if (value > max) begin
            return max;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/bcd_down_counter60_if.sv
// Control, load and display signals of the mod-60 BCD down-counter.
// The master side drives load/enable; the slave side is the counter.
interface bcd_down_counter60_if;
    logic       ld_n;
    logic       en;
    logic [2:0] d_tens;
    logic [3:0] d_ones;
    logic       Q6, Q5, Q4;
    logic       Q3, Q2, Q1, Q0;
    logic       bo;
    logic       zero;
    logic       done;

    modport master (
        output ld_n, en, d_tens, d_ones,
        input  Q6, Q5, Q4, Q3, Q2, Q1, Q0, bo, zero, done
    );

    modport slave (
        input  ld_n, en, d_tens, d_ones,
        output Q6, Q5, Q4, Q3, Q2, Q1, Q0, bo, zero, done
    );
endinterface

// File: rtl/bcd_down_counter60_digit.sv
// One BCD down-digit: saturating parallel load, decrement on enable,
// reload of MAX on underflow.
module bcd_down_digit
    import bcd_pkg::*;
#(
    parameter int unsigned MAX = 9,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         is_zero
);

    localparam logic [3:0]   MAX4  = 4'(MAX);
    localparam logic [W-1:0] MAX_W = W'(MAX);
    localparam logic [W-1:0] ONE_W = W'(1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] d_sat_s;

    assign d_sat_s = W'(bcd_sat(4'(d), MAX4));

    // Next digit value: load beats decrement, decrement from 0 reloads MAX.
    always_comb begin
        q_d = q_q;
        if (!ld_n) begin
            q_d = d_sat_s;
        end else if (en) begin
            if (q_q == '0) begin
                q_d = MAX_W;
            end else begin
                q_d = q_q - ONE_W;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_zero = (q_q == '0);

endmodule

// File: rtl/bcd_down_counter60.sv
// Mod-60 BCD down-counter (59..00) built from two cascaded down-digits, with
// optional wrap at 00, a combinational ripple borrow and a registered done pulse.
module bcd_down_counter60
    import bcd_pkg::*;
#(
    parameter int unsigned AUTO_WRAP = 1,
    parameter int unsigned TENS_MAX  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_down_counter60_if.slave  bus
);

    localparam logic      WRAP_EN = (AUTO_WRAP != 0) ? 1'b1 : 1'b0;
    localparam bcd_pair_t COUNT_ONE = '{tens: 4'd0, ones: 4'd1};

    logic [3:0] ones_q_s;
    logic [2:0] tens_q_s;
    logic       ones_zero_s;
    logic       tens_zero_s;
    logic       zero_s;
    logic       cnt_en_s;
    logic       tens_en_s;
    bcd_pair_t  cnt_s;
    logic       done_q;
    logic       done_d;

    assign zero_s = ones_zero_s & tens_zero_s;

    // In one-shot mode the digits are frozen at 00 so no underflow reload happens.
    assign cnt_en_s  = bus.en & (WRAP_EN | ~zero_s);
    assign tens_en_s = cnt_en_s & ones_zero_s;

    bcd_down_digit #(.MAX(BCD_MAX_ONES), .W(4)) u_ones (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_n    (bus.ld_n),
        .en      (cnt_en_s),
        .d       (bus.d_ones),
        .q       (ones_q_s),
        .is_zero (ones_zero_s)
    );

    bcd_down_digit #(.MAX(TENS_MAX), .W(3)) u_tens (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_n    (bus.ld_n),
        .en      (tens_en_s),
        .d       (bus.d_tens),
        .q       (tens_q_s),
        .is_zero (tens_zero_s)
    );

    assign cnt_s.tens = {1'b0, tens_q_s};
    assign cnt_s.ones = ones_q_s;

    // done only marks the 01 -> 00 decrement; loads, holds and wraps clear it.
    always_comb begin
        done_d = 1'b0;
        if (bus.ld_n && cnt_en_s && (cnt_s == COUNT_ONE)) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // done pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign {bus.Q6, bus.Q5, bus.Q4}         = tens_q_s;
    assign {bus.Q3, bus.Q2, bus.Q1, bus.Q0} = ones_q_s;
    assign bus.zero = zero_s;
    assign bus.bo   = bus.en & zero_s;
    assign bus.done = done_q;

endmodule

// File: tb/tb_bcd_down_counter60.sv
// Directed and random checks of the mod-60 BCD down-counter in wrap and
// one-shot builds against a decimal-arithmetic reference model.
module tb_bcd_down_counter60;

    localparam int TM = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_down_counter60_if if_w ();
    bcd_down_counter60_if if_n ();

    bcd_down_counter60 #(.AUTO_WRAP(1), .TENS_MAX(TM)) dut_w (
        .clk (clk), .rst_n (rst_n), .bus (if_w.slave)
    );
    bcd_down_counter60 #(.AUTO_WRAP(0), .TENS_MAX(TM)) dut_n (
        .clk (clk), .rst_n (rst_n), .bus (if_n.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   m_w, m_n;
    bit   d_w, d_n;
    logic cur_en;

    function automatic int nxt(int v, logic ldn, logic e, int t, int o, bit wrap);
        if (!ldn) return ((t > TM) ? TM : t) * 10 + ((o > 9) ? 9 : o);
        if (!e) return v;
        if (v == 0) return wrap ? (TM * 10 + 9) : 0;
        return v - 1;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_w_tens"}, {5'd0, if_w.Q6, if_w.Q5, if_w.Q4}, 8'(m_w / 10));
        chk({tag, "_w_ones"}, {4'd0, if_w.Q3, if_w.Q2, if_w.Q1, if_w.Q0}, 8'(m_w % 10));
        chk({tag, "_w_zero"}, {7'd0, if_w.zero}, {7'd0, (m_w == 0)});
        chk({tag, "_w_bo"},   {7'd0, if_w.bo},   {7'd0, cur_en & (m_w == 0)});
        chk({tag, "_w_done"}, {7'd0, if_w.done}, {7'd0, d_w});
        chk({tag, "_n_tens"}, {5'd0, if_n.Q6, if_n.Q5, if_n.Q4}, 8'(m_n / 10));
        chk({tag, "_n_ones"}, {4'd0, if_n.Q3, if_n.Q2, if_n.Q1, if_n.Q0}, 8'(m_n % 10));
        chk({tag, "_n_zero"}, {7'd0, if_n.zero}, {7'd0, (m_n == 0)});
        chk({tag, "_n_bo"},   {7'd0, if_n.bo},   {7'd0, cur_en & (m_n == 0)});
        chk({tag, "_n_done"}, {7'd0, if_n.done}, {7'd0, d_n});
    endtask

    task automatic apply(logic ldn, logic e, logic [2:0] t, logic [3:0] o);
        if_w.ld_n = ldn; if_w.en = e; if_w.d_tens = t; if_w.d_ones = o;
        if_n.ld_n = ldn; if_n.en = e; if_n.d_tens = t; if_n.d_ones = o;
        cur_en = e;
    endtask

    task automatic step(string tag, logic ldn, logic e, logic [2:0] t, logic [3:0] o);
        apply(ldn, e, t, o);
        @(posedge clk);
        d_w = ldn & e & (m_w == 1);
        d_n = ldn & e & (m_n == 1);
        m_w = nxt(m_w, ldn, e, int'(t), int'(o), 1'b1);
        m_n = nxt(m_n, ldn, e, int'(t), int'(o), 1'b0);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        apply(1'b1, 1'b1, 3'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        m_w = 0; m_n = 0; d_w = 1'b0; d_n = 1'b0;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step("hold00", 1'b1, 1'b0, 3'd0, 4'd0);

        step("ld25", 1'b0, 1'b0, 3'd2, 4'd5);
        repeat (6) step("dec25", 1'b1, 1'b1, 3'd0, 4'd0);

        step("ld01", 1'b0, 1'b0, 3'd0, 4'd1);
        repeat (3) step("wrap", 1'b1, 1'b1, 3'd0, 4'd0);

        step("ld02", 1'b0, 1'b0, 3'd0, 4'd2);
        repeat (5) step("oneshot", 1'b1, 1'b1, 3'd0, 4'd0);

        step("ldsat", 1'b0, 1'b0, 3'd7, 4'd15);
        step("ldpri", 1'b0, 1'b1, 3'd3, 4'd3);
        step("hold33", 1'b1, 1'b0, 3'd0, 4'd0);

        step("ld45", 1'b0, 1'b0, 3'd4, 4'd5);
        repeat (3) step("dec45", 1'b1, 1'b1, 3'd0, 4'd0);
        #3 rst_n = 1'b0;
        #1;
        m_w = 0; m_n = 0; d_w = 1'b0; d_n = 1'b0;
        check_all("arst");
        #2 rst_n = 1'b1;
        repeat (3) step("resume", 1'b1, 1'b1, 3'd0, 4'd0);

        for (int i = 0; i < 400; i++) begin
            step("rand", logic'(($urandom % 8) != 0), logic'(($urandom % 4) != 0),
                 3'($urandom % 8), 4'($urandom % 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
